aes_enc_feeder: RTL and testbench
=================================

Name: aes_enc_feeder

Overview:
- Upstream stage of the pipelined AES-128 encryptor. Sits between the system-side block source and the encryptor's IN/KEY/enable/fsm_en inputs.
- Buffers plaintext blocks with a valid/ready handshake and issues at most one block per cycle into the 11-stage round pipeline.
- Owns key changes: stops issue, drains in-flight blocks, triggers key-schedule generation, waits for it to finish, then resumes streaming.

Parameters:
- BLOCK_LENGTH, 128, plaintext/key width in bits.
- DEPTH, 4, input FIFO entries; power of two, at least 2.
- PIPE_DEPTH, 11, cycles from aes_enable to that block leaving the encryptor.
- KEY_WAIT_CYCLES, 12, cycles after the aes_fsm_en pulse until round keys k0..k10 are stable.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_data  in  BLOCK_LENGTH  plaintext block from the source.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept; a transfer occurs when s_valid and s_ready are both high on an edge.
- key_in  in  BLOCK_LENGTH  new cipher key.
- key_load  in  1  one-cycle request to switch to key_in.
- key_busy  out  1  high whenever state is not RUN.
- aes_in  out  BLOCK_LENGTH  registered block to the encryptor IN.
- aes_key  out  BLOCK_LENGTH  registered key to the encryptor KEY.
- aes_enable  out  1  registered; aes_in is valid this cycle.
- aes_fsm_en  out  1  registered one-cycle pulse that starts the key-schedule FSM.
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset values:
  - state = IDLE.
  - aes_in, aes_key, aes_enable, aes_fsm_en = 0.
  - FIFO empty; fifo_level = 0.
  - s_ready = 1.
  - key_busy = 1.
  - pending key flag cleared.
- s_ready = !full in every state. There is no bypass; a push while full is impossible by construction. The FIFO fills in all states and issues only in RUN.
- States:
  - IDLE: no valid key. On key_load, latch key_in into the pending register and go to KEYGEN.
  - KEYGEN:
    - On entry: aes_key <= pending key, pending flag cleared, aes_fsm_en pulses high for exactly one cycle, wait counter cleared.
    - Count KEY_WAIT_CYCLES cycles.
    - At completion: if the pending flag is set, re-enter KEYGEN with the new key; otherwise go to RUN.
  - RUN:
    - Each cycle the FIFO is non-empty: pop the head into aes_in and set aes_enable=1.
    - When the FIFO is empty: aes_enable=0 and aes_in=0.
    - On key_load: latch key_in, stop issue the same edge (no pop), and go to DRAIN.
  - DRAIN: aes_enable=0. Count PIPE_DEPTH cycles, then go to KEYGEN.
- A key_load during DRAIN or KEYGEN overwrites the pending key and sets the pending flag. In DRAIN the newest key is used at KEYGEN entry. Only the most recent key_load value is ever applied.
- Latency: a block accepted on edge N appears on aes_in with aes_enable=1 after edge N+1 at the earliest, when in RUN with the FIFO otherwise empty. Blocks are issued in FIFO order, with no gaps while the FIFO is non-empty.
- A push and a pop on the same edge leave fifo_level unchanged. Pointers wrap modulo DEPTH.
- aes_key never changes while any issued block can still be in flight. It changes only on KEYGEN entry.
- Reset mid-operation returns to IDLE and discards the FIFO contents and any pending key. The encryptor must be reset on the same rst.

Optional Feature:
- Macro AES_FEED_STATS_EN.
- When defined, add two outputs:
  - blk_count (32 bits): increments on each cycle with aes_enable=1.
  - stall_count (32 bits): increments on each cycle with s_valid=1 and s_ready=0.
  - Both clear on rst and wrap at 2^32.
- When not defined, these ports and counters do not exist and all other behaviour is identical.

Decomposition:
- Package aes_feed_pkg holds:
  - the state enum (IDLE, KEYGEN, RUN, DRAIN);
  - default constants AES_PIPE_DEPTH=11 and AES_KEY_WAIT=12;
  - the block width constant 128.
- One sub-module, aes_feed_fifo: synchronous FIFO with push/pop, full/empty and level. The top level holds the FSM, counters and output registers.

Test Plan:
- Reset, then key_load with key 000102..0f. Expect:
  - aes_fsm_en pulses exactly once, one cycle after key_load;
  - key_busy stays high for KEY_WAIT_CYCLES cycles, then drops;
  - aes_key = 000102..0f.
- In RUN, push 3 back-to-back blocks 00112233..ff, A, B. Expect aes_enable high for exactly 3 consecutive cycles with the same data in order; fifo_level returns to 0.
- Hold s_valid high with 6 blocks while in IDLE. Expect:
  - s_ready drops after 4 accepts and fifo_level = 4;
  - after the key is loaded, all 4 are issued, then the remaining 2 in order.
- key_load mid-stream with 2 blocks still queued. Expect:
  - aes_enable drops on the next cycle;
  - 11 idle cycles, then an aes_fsm_en pulse, 12 cycles of wait;
  - the queued blocks are issued after the new aes_key is applied.
- Two key_loads (K1, then K2 three cycles later during KEYGEN). Expect a second KEYGEN pass with aes_key = K2 and two aes_fsm_en pulses in total.
- Assert rst during DRAIN with 2 queued blocks. Expect IDLE, fifo_level = 0 and aes_enable = 0 on the next cycle; no block is issued until the next key_load and KEYGEN complete.

Source files
------------

// File: rtl/aes_feed_pkg.sv
// Shared types and default constants for the AES-128 encryptor feeder.
package aes_feed_pkg;

    localparam int AES_BLOCK_LEN  = 128;
    localparam int AES_PIPE_DEPTH = 11;
    localparam int AES_KEY_WAIT   = 12;

    typedef enum logic [1:0] {
        IDLE,
        KEYGEN,
        RUN,
        DRAIN
    } feed_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aes_feed_fifo.sv
// Synchronous FIFO for plaintext blocks: first-word-fall-through head, occupancy level.
module aes_feed_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/aes_enc_feeder.sv
// Feeds buffered plaintext blocks into the pipelined AES-128 encryptor and sequences key changes.
// Optional statistics counters (blk_count, stall_count) are enabled with `define AES_FEED_STATS_EN.
module aes_enc_feeder
    import aes_feed_pkg::*;
#(
    parameter int BLOCK_LENGTH    = AES_BLOCK_LEN,
    parameter int DEPTH           = 4,
    parameter int PIPE_DEPTH      = AES_PIPE_DEPTH,
    parameter int KEY_WAIT_CYCLES = AES_KEY_WAIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BLOCK_LENGTH-1:0]      s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [BLOCK_LENGTH-1:0]      key_in,
    input  logic                         key_load,
    output logic                         key_busy,
    output logic [BLOCK_LENGTH-1:0]      aes_in,
    output logic [BLOCK_LENGTH-1:0]      aes_key,
    output logic                         aes_enable,
    output logic                         aes_fsm_en,
`ifdef AES_FEED_STATS_EN
    output logic [31:0]                  blk_count,
    output logic [31:0]                  stall_count,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int CNT_W = $clog2(max_int(PIPE_DEPTH, KEY_WAIT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(KEY_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH - 1);

    feed_state_t              state;
    feed_state_t              state_d;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_d;
    logic [BLOCK_LENGTH-1:0]  pend_key;
    logic [BLOCK_LENGTH-1:0]  pend_key_d;
    logic                     pend_flag;
    logic                     pend_flag_d;
    logic [BLOCK_LENGTH-1:0]  aes_key_d;
    logic [BLOCK_LENGTH-1:0]  aes_in_d;
    logic                     aes_en_d;
    logic                     fsm_en_d;
    logic                     enter_keygen;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [BLOCK_LENGTH-1:0]  fifo_head;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign key_busy  = (state != RUN);

    aes_feed_fifo #(
        .WIDTH (BLOCK_LENGTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The newest key always wins: pend_key_d already folds in a same-cycle key_load,
    // so KEYGEN entry can take it directly without a one-cycle lag.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        pend_key_d   = key_load ? key_in : pend_key;
        pend_flag_d  = pend_flag;
        aes_key_d    = aes_key;
        aes_in_d     = '0;
        aes_en_d     = 1'b0;
        fsm_en_d     = 1'b0;
        fifo_pop     = 1'b0;
        enter_keygen = 1'b0;

        case (state)
            IDLE: begin
                if (key_load) begin
                    enter_keygen = 1'b1;
                end
            end
            KEYGEN: begin
                cnt_d = cnt + CNT_W'(1);
                if (key_load) begin
                    pend_flag_d = 1'b1;
                end
                if (cnt == WAIT_LAST) begin
                    if (pend_flag || key_load) begin
                        enter_keygen = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (key_load) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    aes_in_d = fifo_head;
                    aes_en_d = 1'b1;
                end
            end
            DRAIN: begin
                cnt_d = cnt + CNT_W'(1);
                if (key_load) begin
                    pend_flag_d = 1'b1;
                end
                if (cnt == DRAIN_LAST) begin
                    enter_keygen = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_keygen) begin
            state_d     = KEYGEN;
            cnt_d       = '0;
            aes_key_d   = pend_key_d;
            pend_flag_d = 1'b0;
            fsm_en_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            pend_key   <= '0;
            pend_flag  <= 1'b0;
            aes_key    <= '0;
            aes_in     <= '0;
            aes_enable <= 1'b0;
            aes_fsm_en <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            pend_key   <= pend_key_d;
            pend_flag  <= pend_flag_d;
            aes_key    <= aes_key_d;
            aes_in     <= aes_in_d;
            aes_enable <= aes_en_d;
            aes_fsm_en <= fsm_en_d;
        end
    end

`ifdef AES_FEED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count   <= '0;
            stall_count <= '0;
        end else begin
            if (aes_enable) begin
                blk_count <= blk_count + 32'd1;
            end
            if (s_valid && !s_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_enc_feeder.sv
// Directed, table-driven bench for aes_enc_feeder (default build, statistics disabled).
module tb_aes_enc_feeder;

    localparam int BL = 128;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [BL-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BL-1:0] key_in;
    logic          key_load;
    logic          key_busy;
    logic [BL-1:0] aes_in;
    logic [BL-1:0] aes_key;
    logic          aes_enable;
    logic          aes_fsm_en;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    aes_enc_feeder #(
        .BLOCK_LENGTH    (BL),
        .DEPTH           (4),
        .PIPE_DEPTH      (11),
        .KEY_WAIT_CYCLES (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .key_in     (key_in),
        .key_load   (key_load),
        .key_busy   (key_busy),
        .aes_in     (aes_in),
        .aes_key    (aes_key),
        .aes_enable (aes_enable),
        .aes_fsm_en (aes_fsm_en),
        .fifo_level (fifo_level)
    );

    typedef struct {
        logic          valid;
        logic [BL-1:0] data;
        logic          exp_en;
        logic [BL-1:0] exp_in;
        logic [LW-1:0] exp_level;
        logic          exp_ready;
    } vec_t;

    vec_t          vecs[10];
    logic [BL-1:0] pblk[6];
    logic [BL-1:0] rblk[4];

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [BL-1:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BL-1:0] K1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [BL-1:0] K2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [BL-1:0] K3 = 128'hdead_beef_0000_1111_cafe_f00d_2222_3333;
    localparam logic [BL-1:0] K4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [BL-1:0] K5 = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
    localparam logic [BL-1:0] K6 = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
    localparam logic [BL-1:0] K7 = 128'h7777_1234_7777_5678_7777_9abc_7777_def0;
    localparam logic [BL-1:0] D0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BL-1:0] DA = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa;
    localparam logic [BL-1:0] DB = 128'hbbbbbbbb_bbbbbbbb_bbbbbbbb_bbbbbbbb;
    localparam logic [BL-1:0] S0 = 128'h5050_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [BL-1:0] S1 = 128'h5151_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [BL-1:0] S2 = 128'h5252_0000_0000_0000_0000_0000_0000_0002;

    int   cycles;
    int   pulses;
    int   idx;
    int   second_at;
    int   src;
    int   got;
    int   gaps;
    int   bad;
    logic started;
    logic xfer;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [BL-1:0] d,
                                 input logic kl, input logic [BL-1:0] k);
        s_valid  = v;
        s_data   = d;
        key_load = kl;
        key_in   = k;
    endtask

    task automatic checkOutput(input string name, input logic [BL-1:0] act,
                               input logic [BL-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, 1'b0, '0);
            tick();
            checkOutput($sformatf("row%0d aes_enable", i), BL'(aes_enable), BL'(vecs[i].exp_en));
            checkOutput($sformatf("row%0d aes_in", i), aes_in, vecs[i].exp_in);
            checkOutput($sformatf("row%0d fifo_level", i), BL'(fifo_level), BL'(vecs[i].exp_level));
            checkOutput($sformatf("row%0d s_ready", i), BL'(s_ready), BL'(vecs[i].exp_ready));
        end
    endtask

    // Counts observed cycles with key_busy high (from the current one) and fsm_en pulses among them.
    task automatic wait_busy_low(input int max, output int c, output int p);
        c = 0;
        p = 0;
        while (key_busy && c < max) begin
            if (aes_fsm_en) p++;
            tick();
            c++;
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) pblk[i] = {32'hb10c0000 + 32'(i), 96'h0123456789abcdef01234567};
        for (int i = 0; i < 4; i++) rblk[i] = {96'hfedcba9876543210fedcba98, 32'hc0de0000 + 32'(i)};

        // In RUN: three back-to-back blocks, issued one cycle after acceptance.
        vecs[0] = '{1'b1, D0,  1'b0, '0, 3'd1, 1'b1};
        vecs[1] = '{1'b1, DA,  1'b1, D0, 3'd1, 1'b1};
        vecs[2] = '{1'b1, DB,  1'b1, DA, 3'd1, 1'b1};
        vecs[3] = '{1'b0, '0,  1'b1, DB, 3'd0, 1'b1};
        vecs[4] = '{1'b0, '0,  1'b0, '0, 3'd0, 1'b1};
        // In IDLE: FIFO fills to DEPTH and back-pressures, nothing issued.
        vecs[5] = '{1'b1, pblk[0], 1'b0, '0, 3'd1, 1'b1};
        vecs[6] = '{1'b1, pblk[1], 1'b0, '0, 3'd2, 1'b1};
        vecs[7] = '{1'b1, pblk[2], 1'b0, '0, 3'd3, 1'b1};
        vecs[8] = '{1'b1, pblk[3], 1'b0, '0, 3'd4, 1'b0};
        vecs[9] = '{1'b1, pblk[4], 1'b0, '0, 3'd4, 1'b0};

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        repeat (3) tick();
        checkOutput("rst aes_enable", BL'(aes_enable), '0);
        checkOutput("rst aes_fsm_en", BL'(aes_fsm_en), '0);
        checkOutput("rst aes_key", aes_key, '0);
        checkOutput("rst aes_in", aes_in, '0);
        checkOutput("rst fifo_level", BL'(fifo_level), '0);
        checkOutput("rst s_ready", BL'(s_ready), BL'(1));
        checkOutput("rst key_busy", BL'(key_busy), BL'(1));
        rst = 1'b0;
        tick();

        // First key load
        applyStimulus(1'b0, '0, 1'b1, K0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("k0 fsm_en pulse", BL'(aes_fsm_en), BL'(1));
        checkOutput("k0 aes_key", aes_key, K0);
        wait_busy_low(40, cycles, pulses);
        checkOutput("k0 busy cycles", BL'(cycles), BL'(12));
        checkOutput("k0 fsm_en pulses", BL'(pulses), BL'(1));
        checkOutput("k0 fsm_en low in RUN", BL'(aes_fsm_en), '0);
        checkOutput("k0 aes_key in RUN", aes_key, K0);

        run_rows(0, 4);

        // IDLE fill with six offered blocks, then stream them after a key load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_rows(5, 9);
        applyStimulus(1'b1, pblk[4], 1'b1, K1);
        tick();
        applyStimulus(1'b1, pblk[4], 1'b0, '0);
        src = 4;
        got = 0;
        gaps = 0;
        started = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            if (aes_enable) begin
                checkOutput($sformatf("stream blk%0d", got), aes_in, pblk[got]);
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            xfer = s_valid && s_ready;
            tick();
            if (xfer) src++;
            if (src < 6) applyStimulus(1'b1, pblk[src], 1'b0, '0);
            else         applyStimulus(1'b0, '0, 1'b0, '0);
        end
        checkOutput("stream issued count", BL'(got), BL'(6));
        checkOutput("stream gaps", BL'(gaps), '0);
        checkOutput("stream accepted count", BL'(src), BL'(6));
        checkOutput("stream aes_key", aes_key, K1);
        checkOutput("stream end aes_enable", BL'(aes_enable), '0);
        checkOutput("stream end fifo_level", BL'(fifo_level), '0);

        // Key change from RUN; four blocks queued while draining / generating
        applyStimulus(1'b0, '0, 1'b1, K2);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, rblk[i], 1'b0, '0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        wait_busy_low(60, cycles, pulses);
        checkOutput("k2 remaining busy cycles", BL'(cycles), BL'(19));
        checkOutput("k2 fsm_en pulses", BL'(pulses), BL'(1));
        checkOutput("k2 aes_key", aes_key, K2);
        checkOutput("k2 fifo_level", BL'(fifo_level), BL'(4));
        checkOutput("k2 first RUN cycle idle", BL'(aes_enable), '0);
        tick();
        checkOutput("k2 issue r0", aes_in, rblk[0]);
        tick();
        checkOutput("k2 issue r1", aes_in, rblk[1]);
        checkOutput("k2 level with 2 queued", BL'(fifo_level), BL'(2));

        // Mid-stream key load: issue stops, drain, regenerate, then remaining blocks
        applyStimulus(1'b0, '0, 1'b1, K3);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("k3 aes_enable drops", BL'(aes_enable), '0);
        checkOutput("k3 level held", BL'(fifo_level), BL'(2));
        checkOutput("k3 aes_key held in DRAIN", aes_key, K2);
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            if (aes_enable || aes_fsm_en) bad++;
            tick();
        end
        checkOutput("k3 drain activity", BL'(bad), '0);
        checkOutput("k3 fsm_en after drain", BL'(aes_fsm_en), BL'(1));
        checkOutput("k3 aes_key", aes_key, K3);
        wait_busy_low(40, cycles, pulses);
        checkOutput("k3 busy cycles", BL'(cycles), BL'(12));
        checkOutput("k3 fsm_en pulses", BL'(pulses), BL'(1));
        checkOutput("k3 first RUN cycle idle", BL'(aes_enable), '0);
        tick();
        checkOutput("k3 issue r2 en", BL'(aes_enable), BL'(1));
        checkOutput("k3 issue r2", aes_in, rblk[2]);
        tick();
        checkOutput("k3 issue r3", aes_in, rblk[3]);
        checkOutput("k3 level empty", BL'(fifo_level), '0);
        tick();
        checkOutput("k3 idle after queue", BL'(aes_enable), '0);

        // Second key_load during KEYGEN forces a second KEYGEN pass
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, K4);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("k4 aes_key", aes_key, K4);
        checkOutput("k4 fsm_en", BL'(aes_fsm_en), BL'(1));
        idx = 0;
        pulses = 0;
        second_at = -1;
        while (key_busy && idx < 80) begin
            if (aes_fsm_en) begin
                pulses++;
                if (pulses == 2) second_at = idx;
            end
            if (idx == 2) applyStimulus(1'b0, '0, 1'b1, K5);
            else          applyStimulus(1'b0, '0, 1'b0, '0);
            tick();
            idx++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("k5 busy cycles", BL'(idx), BL'(24));
        checkOutput("k5 fsm_en pulses", BL'(pulses), BL'(2));
        checkOutput("k5 second pulse cycle", BL'(second_at), BL'(12));
        checkOutput("k5 aes_key", aes_key, K5);

        // Reset during DRAIN with two queued blocks
        applyStimulus(1'b1, S0, 1'b1, K6);
        tick();
        applyStimulus(1'b1, S1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("drain level before rst", BL'(fifo_level), BL'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("drain rst fifo_level", BL'(fifo_level), '0);
        checkOutput("drain rst aes_enable", BL'(aes_enable), '0);
        checkOutput("drain rst key_busy", BL'(key_busy), BL'(1));
        checkOutput("drain rst aes_key", aes_key, '0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (aes_enable || aes_fsm_en || !key_busy) bad++;
            tick();
        end
        checkOutput("post-rst idle activity", BL'(bad), '0);
        applyStimulus(1'b1, S2, 1'b1, K7);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0);
        wait_busy_low(40, cycles, pulses);
        checkOutput("k7 busy cycles", BL'(cycles), BL'(12));
        checkOutput("k7 fsm_en pulses", BL'(pulses), BL'(1));
        checkOutput("k7 aes_key", aes_key, K7);
        tick();
        checkOutput("k7 issue en", BL'(aes_enable), BL'(1));
        checkOutput("k7 first block is new", aes_in, S2);
        checkOutput("k7 level empty", BL'(fifo_level), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
